// File: rtl/hsv_core_mem_pkg.sv
// Shared memory-stage types: access size/direction, LSU state, exception causes.
// Also provides the alignment and cause-selection helpers used by the LSU.
package hsv_core_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_direction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } lsu_state_t;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

  typedef struct packed {
    logic [1:0]     offset;
    mem_size_t      size;
    mem_direction_t direction;
    logic           sign_extend;
    logic [4:0]     tag;
  } lsu_op_t;

  function automatic logic is_misaligned(mem_size_t size, logic [1:0] offset);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return offset[0];
      default:  return offset != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] cause_for(mem_direction_t dir, logic fault);
    if (dir == MEM_WRITE) return fault ? CAUSE_STORE_FAULT : CAUSE_STORE_MISALIGNED;
    else                  return fault ? CAUSE_LOAD_FAULT  : CAUSE_LOAD_MISALIGNED;
  endfunction

endpackage

// File: rtl/hsv_core_mem_lsu_ctrl_if.sv
// Issue, memory-port and result signals of the LSU controller.
// master = LSU side (drives the bus request and result), slave = surrounding pipeline/bus.
interface hsv_core_mem_lsu_ctrl_if;
  import hsv_core_mem_pkg::*;

  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_addr;
  mem_size_t      in_size;
  mem_direction_t in_direction;
  logic           in_sign_extend;
  logic [31:0]    in_wdata;
  logic [4:0]     in_tag;
  logic           mem_req_valid;
  logic           mem_req_ready;
  logic [31:0]    mem_req_addr;
  logic           mem_req_write;
  logic [3:0]     mem_req_strb;
  logic [31:0]    mem_req_wdata;
  logic           mem_rsp_valid;
  logic [31:0]    mem_rsp_rdata;
  logic           mem_rsp_error;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_rdata;
  logic [4:0]     out_tag;
  logic           out_exception;
  logic [3:0]     out_cause;

  modport master (
    input  flush, in_valid, in_addr, in_size, in_direction, in_sign_extend, in_wdata, in_tag,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, mem_req_write, mem_req_strb, mem_req_wdata,
           out_valid, out_rdata, out_tag, out_exception, out_cause
  );

  modport slave (
    output flush, in_valid, in_addr, in_size, in_direction, in_sign_extend, in_wdata, in_tag,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_error, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, mem_req_write, mem_req_strb, mem_req_wdata,
           out_valid, out_rdata, out_tag, out_exception, out_cause
  );
endinterface

// File: rtl/hsv_core_mem_lsu_lanes.sv
// Byte-lane steering: store strobes/replicated data and load extraction/extension.
// Purely combinational so a cache path can reuse it.
module hsv_core_mem_lsu_lanes
  import hsv_core_mem_pkg::*;
(
  input  logic [1:0]  st_offset,
  input  mem_size_t   st_size,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_offset,
  input  mem_size_t   ld_size,
  input  logic        ld_sign_extend,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [31:0] shifted;

  always_comb begin
    st_strb      = 4'b1111;
    st_wdata_rep = st_wdata;
    case (st_size)
      MEM_BYTE: begin
        st_strb      = 4'b0001 << st_offset;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      MEM_HALF: begin
        st_strb      = 4'b0011 << st_offset;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_size)
      MEM_BYTE: ld_data = {{24{ld_sign_extend & shifted[7]}}, shifted[7:0]};
      MEM_HALF: ld_data = {{16{ld_sign_extend & shifted[15]}}, shifted[15:0]};
      default:  ;
    endcase
  end
endmodule

// File: rtl/hsv_core_mem_lsu_ctrl.sv
// Load/store sequencer: one outstanding access on a 32-bit port, result with RISC-V causes.
// Optional response timeout with orphan-response tracking: HSV_CORE_MEM_LSU_TIMEOUT_EN.
//   state | meaning
//   IDLE  | ready for a new op
//   REQ   | bus request presented, waiting for mem_req_ready
//   WAIT  | request accepted, waiting for mem_rsp_valid
//   DONE  | result presented, waiting for out_ready
//   DRAIN | flushed with a response still owed; swallow it
module hsv_core_mem_lsu_ctrl
  import hsv_core_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                     clk_core,
  input logic                     rst_core_n,
  hsv_core_mem_lsu_ctrl_if.master lsu
);
  lsu_state_t  state;
  lsu_op_t     op;
  logic        accept, req_hs, rsp, misaligned, orphan, timeout;
  logic        req_valid, req_write, out_valid_q, out_exc_q;
  logic [31:0] req_addr, req_wdata, out_rdata_q, st_wdata, ld_data;
  logic [3:0]  req_strb, st_strb, out_cause_q;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  assign accept     = lsu.in_valid && lsu.in_ready;
  assign req_hs     = req_valid && lsu.mem_req_ready;
  assign rsp        = lsu.mem_rsp_valid && !orphan;
  assign misaligned = is_misaligned(lsu.in_size, lsu.in_addr[1:0]);

  hsv_core_mem_lsu_lanes u_lanes (
    .st_offset      (lsu.in_addr[1:0]),
    .st_size        (lsu.in_size),
    .st_wdata       (lsu.in_wdata),
    .st_strb        (st_strb),
    .st_wdata_rep   (st_wdata),
    .ld_offset      (op.offset),
    .ld_size        (op.size),
    .ld_sign_extend (op.sign_extend),
    .ld_rdata       (lsu.mem_rsp_rdata),
    .ld_data        (ld_data)
  );

`ifdef HSV_CORE_MEM_LSU_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout = (state == WAIT) && !lsu.flush && !rsp &&
                   (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // A timed-out access still owes a response; orphan swallows it wherever it lands.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wait_cnt <= '0;
      orphan   <= 1'b0;
    end else begin
      if (state == REQ)       wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (timeout)                            orphan <= 1'b1;
      else if (orphan && lsu.mem_rsp_valid)   orphan <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign orphan  = 1'b0;
`endif

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state       <= IDLE;
      op          <= '0;
      req_valid   <= 1'b0;
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_strb    <= '0;
      req_wdata   <= '0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_exc_q   <= 1'b0;
      out_cause_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op <= '{offset: lsu.in_addr[1:0], size: lsu.in_size, direction: lsu.in_direction,
                  sign_extend: lsu.in_sign_extend, tag: lsu.in_tag};
          if (misaligned) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_exc_q   <= 1'b1;
            out_cause_q <= cause_for(lsu.in_direction, 1'b0);
            out_rdata_q <= '0;
          end else begin
            state     <= REQ;
            req_valid <= 1'b1;
            req_addr  <= {lsu.in_addr[31:2], 2'b00};
            req_write <= (lsu.in_direction == MEM_WRITE);
            req_strb  <= st_strb;
            req_wdata <= st_wdata;
          end
        end
        REQ: begin
          if (lsu.flush) begin
            req_valid <= 1'b0;
            state     <= req_hs ? DRAIN : IDLE;
          end else if (req_hs) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (lsu.flush) begin
            state <= rsp ? IDLE : DRAIN;
          end else if (rsp) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_exc_q   <= lsu.mem_rsp_error;
            out_cause_q <= lsu.mem_rsp_error ? cause_for(op.direction, 1'b1) : 4'd0;
            out_rdata_q <= (lsu.mem_rsp_error || op.direction == MEM_WRITE) ? 32'd0 : ld_data;
          end else if (timeout) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_exc_q   <= 1'b1;
            out_cause_q <= cause_for(op.direction, 1'b1);
            out_rdata_q <= '0;
          end
        end
        DONE: if (lsu.flush || lsu.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
        DRAIN: if (lsu.flush || rsp) state <= rsp ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu.in_ready      = (state == IDLE) && !lsu.flush && !orphan;
  assign lsu.mem_req_valid = req_valid;
  assign lsu.mem_req_addr  = req_addr;
  assign lsu.mem_req_write = req_write;
  assign lsu.mem_req_strb  = req_strb;
  assign lsu.mem_req_wdata = req_wdata;
  assign lsu.out_valid     = out_valid_q;
  assign lsu.out_rdata     = out_rdata_q;
  assign lsu.out_tag       = op.tag;
  assign lsu.out_exception = out_exc_q;
  assign lsu.out_cause     = out_cause_q;

  a_rsp_unexpected: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    lsu.mem_rsp_valid |-> (state == WAIT || state == DRAIN || orphan));
endmodule

// File: doc/hsv_core_mem_lsu_ctrl.md
Name: hsv_core_mem_lsu_ctrl

Overview:
- Sequences a single decoded load/store (size, direction, sign_extend from the mem decode stage) onto a one-outstanding 32-bit memory port.
- Generates the word-aligned address, byte strobes and replicated store data.
- Waits for the response, then extracts and sign/zero-extends load data, or raises misaligned/access-fault exceptions.
- Sits between the memory execution unit's issue register and the core's data-bus adapter.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a forced access fault. Used only with the optional feature. Range 1..65535.

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills the op in flight
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid&&in_ready
- in_addr  in  32  effective byte address
- in_size  in  2  mem_size_t (BYTE/HALF/WORD)
- in_direction  in  1  mem_direction_t (READ/WRITE)
- in_sign_extend  in  1  loads only; don't-care for stores
- in_wdata  in  32  store data (low bits significant)
- in_tag  in  5  destination register, passed through
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  {in_addr[31:2],2'b00}
- mem_req_write  out  1  1 = store
- mem_req_strb  out  4  byte enables
- mem_req_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  response strobe, single cycle, no backpressure
- mem_rsp_rdata  in  32  load data word
- mem_rsp_error  in  1  bus error on this response
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_rdata  out  32  extended load data; 0 for stores and exceptions
- out_tag  out  5  latched in_tag
- out_exception  out  1  result carries an exception
- out_cause  out  4  RISC-V cause: 4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault

Behaviour:
- Reset: state IDLE. in_ready=1; mem_req_valid=0; out_valid=0; out_rdata, out_tag, out_cause, out_exception, mem_req_* = 0.
- States:
  - IDLE: in_ready = !flush. On accept, latch all inputs. Misaligned (HALF with addr[0]=1, or WORD with addr[1:0]!=0) → DONE with cause 4/6, no bus traffic. Otherwise → REQ.
  - REQ: mem_req_valid=1, outputs stable until mem_req_ready → WAIT.
  - WAIT: on mem_rsp_valid → DONE. mem_rsp_error sets cause 5/7 and out_rdata=0.
  - DONE: out_valid=1, outputs stable until out_ready → IDLE.
  - DRAIN: discards exactly one mem_rsp_valid → IDLE.
- Strobes: BYTE 4'b0001<<a[1:0]; HALF 4'b0011<<a[1:0]; WORD 4'b1111.
- Write data: BYTE {4{wdata[7:0]}}; HALF {2{wdata[15:0]}}; WORD wdata.
- Load data: shift = mem_rsp_rdata >> (8*a[1:0]), then truncate to size; sign_extend=1 replicates bit 7/15, otherwise zero-fill. Registered into out_rdata at the response cycle.
- Minimum latency accept→out_valid is 3 cycles: REQ with ready=1, response next cycle, DONE.
- Flush:
  - REQ without same-cycle handshake → IDLE.
  - REQ with same-cycle handshake → DRAIN.
  - WAIT: no rsp this cycle → DRAIN; rsp this cycle → IDLE.
  - DONE → IDLE; out_valid drops next cycle.
  - Flush takes priority over every other transition.
- mem_rsp_valid outside WAIT/DRAIN is ignored. A response in IDLE, REQ or DONE is an assertion failure in simulation.
- Reset asserted mid-operation: immediately IDLE, all outputs at reset values, no drain. The bus adapter is reset on the same signal.

Optional Feature:
- Macro: HSV_CORE_MEM_LSU_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - At count==TIMEOUT_CYCLES-1 with no response → DONE with cause 5/7, and an orphan flag is set.
  - While the orphan flag is set, the next mem_rsp_valid is discarded in any state and then clears it; REQ is not entered while orphan=1.
  - Flush does not clear orphan.
- Disabled: no counter, no orphan flag; WAIT waits indefinitely.

Decomposition:
- Package hsv_core_mem_pkg:
  - mem_size_t, mem_direction_t (shared with mem decode)
  - lsu_state_t {IDLE, REQ, WAIT, DONE, DRAIN}
  - cause constants CAUSE_LOAD_MISALIGNED=4, CAUSE_LOAD_FAULT=5, CAUSE_STORE_MISALIGNED=6, CAUSE_STORE_FAULT=7
  - lsu_op_t struct for the latched op
- Sub-module hsv_core_mem_lsu_lanes: combinational strobe/wdata generation and load extraction. Reused by any later cache path.

Test Plan:
- LB a=0x1003, rdata=0x80_00_00_00, sign_extend=1, ready=1 → strb ignored on read, out_rdata=0xFFFFFF80, valid 3 cycles after accept.
- SH a=0x2002, wdata=0x0000BEEF → mem_req_addr=0x2000, strb=4'b1100, wdata=0xBEEFBEEF, out_exception=0, out_rdata=0.
- LW a=0x3001 → no mem_req_valid ever, out_exception=1, cause=4; SW a=0x3002 → cause=6.
- LHU a=0x4000 with mem_rsp_error=1 → cause=5, out_rdata=0; stalled out_ready=0 for 5 cycles → outputs held stable.
- Flush in WAIT, response 2 cycles later → no out_valid, response absorbed; next LW a=0x5000, rdata=0x12345678 returns 0x12345678 cleanly.
- With HSV_CORE_MEM_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no response → out_exception cause 5 after 4 WAIT cycles; late response discarded, following load completes correctly.
